bs_serial_sub: RTL and testbench

Bit-serial, LSB-first N-bit subtractor built around a registered single-bit subtract cell with borrow feedback. It accepts two parallel operands on a valid/ready handshake, shifts one bit pair per clock through the subtract cell, and assembles the difference. It returns the parallel difference and final borrow on a second valid/ready handshake. It sits directly downstream of operand producers in the combinational-circuits datapath and replaces a ripple subtractor where area matters more than latency.

---
 rtl/bs_serial_sub.sv | 75 +++++++
 tb/tb_bs_serial_sub.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bs_serial_sub.sv
// bs_serial_sub: bit-serial LSB-first subtractor with valid/ready handshakes on operands and result
module bs_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, br_next;

    // single-bit subtract cell on the current LSB pair and the stored borrow
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // sequencer; the result outputs are captured only on the last shift so they stay still while R shifts
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a_in;
                    b_sh  <= b_in;
                    br    <= 1'b0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= {d, r_sh[WIDTH-1:1]};
                        borrow_out <= br_next;
                        state      <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bs_serial_sub.sv
// tb_bs_serial_sub: directed and random checks of the bit-serial subtractor at WIDTH=8
module tb_bs_serial_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow_out;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bs_serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_diff"}, diff, 0);
        chk({tag, "_borrow"}, borrow_out, 0);
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input string tag);
        int n;
        out_ready = 1'b1;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_out(n);
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow_out, eb);
        tick();
        chk({tag, "_back_idle"}, in_ready, 1);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_diff_kept"}, diff, ed);
    endtask

    initial begin
        int n;
        int last_acc;
        logic [7:0] ra, rb;
        logic [7:0] pa [4] = '{8'd10, 8'd3, 8'd128, 8'd0};
        logic [7:0] pb [4] = '{8'd3, 8'd10, 8'd127, 8'd255};
        logic [7:0] pd [4] = '{8'h07, 8'hF9, 8'h01, 8'h01};
        logic       pw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b1;
        chk_reset("reset");

        run(8'd13, 8'd5, 8'd8, 1'b0, "13-5");
        run(8'd5, 8'd13, 8'hF8, 1'b1, "5-13");
        run(8'd0, 8'd1, 8'hFF, 1'b1, "0-1");
        run(8'hFF, 8'hFF, 8'h00, 1'b0, "ff-ff");

        out_ready = 1'b0;
        a_in = 8'd100;
        b_in = 8'd30;
        in_valid = 1'b1;
        tick();
        a_in = 8'd1;
        b_in = 8'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_shift_in_ready", in_ready, 0);
        end
        wait_out(n);
        chk("bp_latency", n + 3, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_diff", diff, 8'd70);
            chk("bp_borrow", borrow_out, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("done_exit_no_accept", busy, 0);
        chk("done_exit_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("accept_after_idle", busy, 1);
        wait_out(n);
        chk("acc2_diff", diff, 8'hFF);
        chk("acc2_borrow", borrow_out, 1);
        tick();

        a_in = 8'd77;
        b_in = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_reset("midrst");
        tick();
        chk("midrst_stays_idle", busy, 0);
        run(8'd200, 8'd100, 8'd100, 1'b0, "200-100");

        out_ready = 1'b1;
        in_valid = 1'b1;
        last_acc = 0;
        for (int k = 0; k < 4; k++) begin
            a_in = pa[k];
            b_in = pb[k];
            n = 0;
            while (in_ready !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("b2b_ready", in_ready, 1);
            if (k > 0) chk("b2b_spacing", cyc - last_acc, 10);
            last_acc = cyc;
            tick();
            wait_out(n);
            chk("b2b_latency", n, 8);
            chk("b2b_diff", diff, pd[k]);
            chk("b2b_borrow", borrow_out, pw[k]);
            tick();
        end
        in_valid = 1'b0;

        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run(ra, rb, ra - rb, ra < rb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
